pipeline_hazard_unit: RTL and testbench

Parametrised successor to the fixed hazard_control of the 5-stage RV32I core.
- Keeps a scoreboard shadow of the EX and MA stage destinations.
- Drives the per-stage clock enables and the ID/EX bubble controls.
- Optionally forwards operands instead of stalling, and stretches a branch flush over a configurable number of cycles.
- Detects data-memory wait timeouts and counts stall cycles.
- Sits beside the IF/ID/EX/MA stages in the core top, replacing the old hazard_control.

---
 rtl/pipeline_hazard_unit_pkg.sv | 25 ++
 rtl/pipeline_hazard_unit_scoreboard.sv | 76 +++++++
 rtl/pipeline_hazard_unit.sv | 158 +++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: hazard FSM states, operand
// forwarding selects and the per-source RAW match result.
package pipeline_hazard_unit_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'b00,
    HZ_FLUSH    = 2'b01,
    HZ_MEM_WAIT = 2'b10
  } hzState_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MA  = 2'b10
  } fwdSel_t;

  typedef struct packed {
    logic hit_ex;
    logic hit_ma;
  } raw_hit_t;

  // FLUSH_CYCLES is bounded to 1..7, so the remaining-cycle counter fits in 3 bits
  localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/pipeline_hazard_unit_scoreboard.sv
// Shadow of the EX and MA destinations plus the RAW match for both ID sources.
module hazard_scoreboard
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_en,
  input  logic                ma_en,
  input  logic                ex_bubble,
  input  logic [REG_ADDR-1:0] id_rd,
  input  logic                id_reg_wr,
  input  logic                id_mem_rd,
  input  logic                id_mem_wr,
  input  logic [REG_ADDR-1:0] rs1,
  input  logic                rs1_used,
  input  logic [REG_ADDR-1:0] rs2,
  input  logic                rs2_used,
  output raw_hit_t            hit_rs1,
  output raw_hit_t            hit_rs2,
  output logic                ex_ld,
  output logic                ma_mem
);

  logic [REG_ADDR-1:0] ex_rd;
  logic                ex_wr;
  logic                ex_mem;
  logic [REG_ADDR-1:0] ma_rd;
  logic                ma_wr;

  function automatic raw_hit_t raw_match(input logic used, input logic [REG_ADDR-1:0] rs,
                                         input logic [REG_ADDR-1:0] e_rd, input logic e_wr,
                                         input logic [REG_ADDR-1:0] m_rd, input logic m_wr);
    raw_hit_t h;
    h.hit_ex = used && e_wr && (rs == e_rd);
    h.hit_ma = used && m_wr && (rs == m_rd);
    return h;
  endfunction

  // x0 writes are dropped on entry so they can never match a source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd  <= '0;
      ex_wr  <= 1'b0;
      ex_ld  <= 1'b0;
      ex_mem <= 1'b0;
      ma_rd  <= '0;
      ma_wr  <= 1'b0;
      ma_mem <= 1'b0;
    end else begin
      if (ma_en) begin
        ma_rd  <= ex_rd;
        ma_wr  <= ex_wr;
        ma_mem <= ex_mem;
      end
      if (ex_en) begin
        if (ex_bubble) begin
          ex_rd  <= '0;
          ex_wr  <= 1'b0;
          ex_ld  <= 1'b0;
          ex_mem <= 1'b0;
        end else begin
          ex_rd  <= id_rd;
          ex_wr  <= id_reg_wr && (id_rd != '0);
          ex_ld  <= id_mem_rd;
          ex_mem <= id_mem_rd || id_mem_wr;
        end
      end
    end
  end

  assign hit_rs1 = raw_match(rs1_used, rs1, ex_rd, ex_wr, ma_rd, ma_wr);
  assign hit_rs2 = raw_match(rs2_used, rs2, ex_rd, ex_wr, ma_rd, ma_wr);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard control for the 5-stage RV32I core: stage enables, bubbles, operand
// forwarding, multi-cycle branch flush, data-memory timeout and stall counting.
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int          REG_ADDR     = 5,
  parameter int          FWD_EN       = 1,
  parameter int          FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int          CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_instr_ready,
  input  logic                i_data_ready,
  input  logic [REG_ADDR-1:0] i_id_rs1,
  input  logic [REG_ADDR-1:0] i_id_rs2,
  input  logic                i_id_rs1_used,
  input  logic                i_id_rs2_used,
  input  logic [REG_ADDR-1:0] i_id_rd,
  input  logic                i_id_reg_wr,
  input  logic                i_id_mem_rd,
  input  logic                i_id_mem_wr,
  input  logic                i_ex_flush,
  output logic                o_if_clk_en,
  output logic                o_id_clk_en,
  output logic                o_ex_clk_en,
  output logic                o_ma_clk_en,
  output logic                o_id_bubble,
  output logic                o_ex_bubble,
  output logic                o_flush,
  output logic [1:0]          o_fwd_rs1,
  output logic [1:0]          o_fwd_rs2,
  output logic                o_mem_timeout,
  output logic [CNT_W-1:0]    o_stall_cnt
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

  hzState_t               state;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt_nxt;
  logic [TMO_W-1:0]       tmo_cnt;
  raw_hit_t               hit_rs1;
  raw_hit_t               hit_rs2;
  logic                   ex_ld;
  logic                   ma_mem;
  logic                   mem_freeze;
  logic                   flush_act;
  logic                   raw_stall;
  logic                   tmo_reach;

  function automatic fwdSel_t fwd_sel(input raw_hit_t h, input logic ld);
    if (FWD_EN == 0)         return FWD_REG;
    else if (h.hit_ex && !ld) return FWD_EX;
    else if (h.hit_ma)        return FWD_MA;
    else                      return FWD_REG;
  endfunction

  function automatic logic raw_hazard(input raw_hit_t h, input logic ld);
    if (FWD_EN != 0) return h.hit_ex && ld;
    else             return h.hit_ex || h.hit_ma;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  hazard_scoreboard #(.REG_ADDR(REG_ADDR)) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_en     (o_ex_clk_en),
    .ma_en     (o_ma_clk_en),
    .ex_bubble (o_ex_bubble),
    .id_rd     (i_id_rd),
    .id_reg_wr (i_id_reg_wr),
    .id_mem_rd (i_id_mem_rd),
    .id_mem_wr (i_id_mem_wr),
    .rs1       (i_id_rs1),
    .rs1_used  (i_id_rs1_used),
    .rs2       (i_id_rs2),
    .rs2_used  (i_id_rs2_used),
    .hit_rs1   (hit_rs1),
    .hit_rs2   (hit_rs2),
    .ex_ld     (ex_ld),
    .ma_mem    (ma_mem)
  );

  // A flush still owed from before a memory freeze resumes once data returns
  assign mem_freeze = ma_mem && !i_data_ready;
  assign flush_act  = !mem_freeze && (i_ex_flush || (state == HZ_FLUSH) ||
                                      ((state == HZ_MEM_WAIT) && (flush_cnt != '0)));
  assign raw_stall  = raw_hazard(hit_rs1, ex_ld) || raw_hazard(hit_rs2, ex_ld);
  assign tmo_reach  = (32'(tmo_cnt) + 32'd1) >= MEM_TIMEOUT;

  assign o_fwd_rs1 = rst_n ? fwd_sel(hit_rs1, ex_ld) : FWD_REG;
  assign o_fwd_rs2 = rst_n ? fwd_sel(hit_rs2, ex_ld) : FWD_REG;

  always_comb begin
    o_if_clk_en = 1'b0;
    o_id_clk_en = 1'b0;
    o_ex_clk_en = 1'b0;
    o_ma_clk_en = 1'b0;
    o_id_bubble = 1'b0;
    o_ex_bubble = 1'b0;
    o_flush     = 1'b0;
    if (!rst_n || mem_freeze) begin
      o_flush = 1'b0;
    end else if (flush_act) begin
      {o_if_clk_en, o_id_clk_en, o_ex_clk_en, o_ma_clk_en} = 4'hF;
      o_flush     = 1'b1;
      o_ex_bubble = 1'b1;
    end else if (raw_stall) begin
      o_ex_clk_en = 1'b1;
      o_ma_clk_en = 1'b1;
      o_ex_bubble = 1'b1;
    end else if (!i_instr_ready) begin
      o_id_clk_en = 1'b1;
      o_ex_clk_en = 1'b1;
      o_ma_clk_en = 1'b1;
      o_id_bubble = 1'b1;
    end else begin
      {o_if_clk_en, o_id_clk_en, o_ex_clk_en, o_ma_clk_en} = 4'hF;
    end
  end

  always_comb begin
    flush_cnt_nxt = flush_cnt;
    if (!mem_freeze) begin
      if (i_ex_flush)            flush_cnt_nxt = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
      else if (flush_cnt != '0)  flush_cnt_nxt = flush_cnt - FLUSH_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HZ_RUN;
      flush_cnt     <= '0;
      tmo_cnt       <= '0;
      o_mem_timeout <= 1'b0;
      o_stall_cnt   <= '0;
    end else begin
      flush_cnt <= flush_cnt_nxt;
      if (mem_freeze)                state <= HZ_MEM_WAIT;
      else if (flush_cnt_nxt != '0)  state <= HZ_FLUSH;
      else                           state <= HZ_RUN;
      if (mem_freeze) begin
        if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TMO_W'(1);
        if (tmo_reach)          o_mem_timeout <= 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
      if (!o_if_clk_en) o_stall_cnt <= sat_inc(o_stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: a forwarding instance and an interlock instance
// share stimulus and are each compared every cycle against a pipeline-level model.
module tb_pipeline_hazard_unit;

  localparam int RA  = 5;
  localparam int FC  = 3;
  localparam int TMO = 4;
  localparam int CW0 = 16;
  localparam int CW1 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instr_ready = 1'b1;
  logic data_ready = 1'b1;
  logic [RA-1:0] id_rs1 = '0;
  logic [RA-1:0] id_rs2 = '0;
  logic [RA-1:0] id_rd = '0;
  logic rs1_used = 1'b0;
  logic rs2_used = 1'b0;
  logic id_reg_wr = 1'b0;
  logic id_mem_rd = 1'b0;
  logic id_mem_wr = 1'b0;
  logic ex_flush = 1'b0;

  logic [1:0] if_en, id_en, ex_en, ma_en, id_b, ex_b, flush, tmo;
  logic [1:0][1:0] fwd1;
  logic [1:0][1:0] fwd2;
  logic [CW0-1:0] sc0;
  logic [CW1-1:0] sc1;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.REG_ADDR(RA), .FWD_EN(1), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(TMO), .CNT_W(CW0)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .i_instr_ready(instr_ready), .i_data_ready(data_ready),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_id_rd(id_rd), .i_id_reg_wr(id_reg_wr), .i_id_mem_rd(id_mem_rd), .i_id_mem_wr(id_mem_wr),
    .i_ex_flush(ex_flush), .o_if_clk_en(if_en[0]), .o_id_clk_en(id_en[0]), .o_ex_clk_en(ex_en[0]),
    .o_ma_clk_en(ma_en[0]), .o_id_bubble(id_b[0]), .o_ex_bubble(ex_b[0]), .o_flush(flush[0]),
    .o_fwd_rs1(fwd1[0]), .o_fwd_rs2(fwd2[0]), .o_mem_timeout(tmo[0]), .o_stall_cnt(sc0)
  );

  pipeline_hazard_unit #(.REG_ADDR(RA), .FWD_EN(0), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(TMO), .CNT_W(CW1)) dut_ilk (
    .clk(clk), .rst_n(rst_n), .i_instr_ready(instr_ready), .i_data_ready(data_ready),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_id_rd(id_rd), .i_id_reg_wr(id_reg_wr), .i_id_mem_rd(id_mem_rd), .i_id_mem_wr(id_mem_wr),
    .i_ex_flush(ex_flush), .o_if_clk_en(if_en[1]), .o_id_clk_en(id_en[1]), .o_ex_clk_en(ex_en[1]),
    .o_ma_clk_en(ma_en[1]), .o_id_bubble(id_b[1]), .o_ex_bubble(ex_b[1]), .o_flush(flush[1]),
    .o_fwd_rs1(fwd1[1]), .o_fwd_rs2(fwd2[1]), .o_mem_timeout(tmo[1]), .o_stall_cnt(sc1)
  );

  // Model: which instruction sits in EX and MA, flush cycles owed, wait length, counters
  int m_ex_rd [2];
  int m_ma_rd [2];
  int m_left  [2];
  int m_wait  [2];
  int m_sc    [2];
  bit m_ex_wr [2];
  bit m_ex_ld [2];
  bit m_ex_mem[2];
  bit m_ma_wr [2];
  bit m_ma_mem[2];
  bit m_tmo   [2];

  typedef struct {
    bit if_en, id_en, ex_en, ma_en, id_b, ex_b, fl;
    int f1, f2;
  } exp_t;
  exp_t e [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ex_rd[k] = 0; m_ma_rd[k] = 0; m_left[k] = 0; m_wait[k] = 0; m_sc[k] = 0;
      m_ex_wr[k] = 0; m_ex_ld[k] = 0; m_ex_mem[k] = 0;
      m_ma_wr[k] = 0; m_ma_mem[k] = 0; m_tmo[k] = 0;
    end
  endfunction

  function automatic void src_eval(input int k, input bit used, input int rs, output bit hz, output int f);
    bit hit_ex, hit_ma;
    hit_ex = used && (rs == m_ex_rd[k]) && m_ex_wr[k] && (m_ex_rd[k] != 0);
    hit_ma = used && (rs == m_ma_rd[k]) && m_ma_wr[k] && (m_ma_rd[k] != 0);
    if (k == 0) begin
      f  = (hit_ex && !m_ex_ld[k]) ? 1 : (hit_ma ? 2 : 0);
      hz = hit_ex && m_ex_ld[k];
    end else begin
      f  = 0;
      hz = hit_ex || hit_ma;
    end
  endfunction

  function automatic void evaluate(input int k);
    bit hz1, hz2, frz;
    int f1, f2;
    e[k].if_en = 0; e[k].id_en = 0; e[k].ex_en = 0; e[k].ma_en = 0;
    e[k].id_b = 0; e[k].ex_b = 0; e[k].fl = 0; e[k].f1 = 0; e[k].f2 = 0;
    if (!rst_n) return;
    src_eval(k, rs1_used, int'(id_rs1), hz1, f1);
    src_eval(k, rs2_used, int'(id_rs2), hz2, f2);
    e[k].f1 = f1;
    e[k].f2 = f2;
    frz = m_ma_mem[k] && !data_ready;
    if (frz) begin
      e[k].fl = 0;
    end else if (ex_flush || m_left[k] > 0) begin
      e[k].if_en = 1; e[k].id_en = 1; e[k].ex_en = 1; e[k].ma_en = 1;
      e[k].fl = 1; e[k].ex_b = 1;
    end else if (hz1 || hz2) begin
      e[k].ex_en = 1; e[k].ma_en = 1; e[k].ex_b = 1;
    end else if (!instr_ready) begin
      e[k].id_en = 1; e[k].ex_en = 1; e[k].ma_en = 1; e[k].id_b = 1;
    end else begin
      e[k].if_en = 1; e[k].id_en = 1; e[k].ex_en = 1; e[k].ma_en = 1;
    end
  endfunction

  function automatic void advance(input int k);
    bit frz;
    int smax;
    frz  = m_ma_mem[k] && !data_ready;
    smax = (k == 0) ? ((1 << CW0) - 1) : ((1 << CW1) - 1);
    if (!e[k].if_en && m_sc[k] < smax) m_sc[k]++;
    if (frz) begin
      m_wait[k]++;
      if (m_wait[k] >= TMO) m_tmo[k] = 1;
    end else begin
      m_wait[k] = 0;
      if (ex_flush)           m_left[k] = FC - 1;
      else if (m_left[k] > 0) m_left[k]--;
    end
    if (e[k].ma_en) begin
      m_ma_rd[k] = m_ex_rd[k]; m_ma_wr[k] = m_ex_wr[k]; m_ma_mem[k] = m_ex_mem[k];
    end
    if (e[k].ex_en) begin
      if (e[k].ex_b) begin
        m_ex_rd[k] = 0; m_ex_wr[k] = 0; m_ex_ld[k] = 0; m_ex_mem[k] = 0;
      end else begin
        m_ex_rd[k] = int'(id_rd); m_ex_wr[k] = id_reg_wr; m_ex_ld[k] = id_mem_rd;
        m_ex_mem[k] = id_mem_rd || id_mem_wr;
      end
    end
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      evaluate(k);
      chk($sformatf("if_en%0d", k), 32'(if_en[k]), 32'(e[k].if_en));
      chk($sformatf("id_en%0d", k), 32'(id_en[k]), 32'(e[k].id_en));
      chk($sformatf("ex_en%0d", k), 32'(ex_en[k]), 32'(e[k].ex_en));
      chk($sformatf("ma_en%0d", k), 32'(ma_en[k]), 32'(e[k].ma_en));
      chk($sformatf("id_bub%0d", k), 32'(id_b[k]), 32'(e[k].id_b));
      chk($sformatf("ex_bub%0d", k), 32'(ex_b[k]), 32'(e[k].ex_b));
      chk($sformatf("flush%0d", k), 32'(flush[k]), 32'(e[k].fl));
      chk($sformatf("fwd_rs1_%0d", k), 32'(fwd1[k]), e[k].f1);
      chk($sformatf("fwd_rs2_%0d", k), 32'(fwd2[k]), e[k].f2);
      chk($sformatf("timeout%0d", k), 32'(tmo[k]), 32'(m_tmo[k]));
    end
    chk("stall_cnt0", 32'(sc0), m_sc[0]);
    chk("stall_cnt1", 32'(sc1), m_sc[1]);
  endtask

  task automatic sample();
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      advance(0);
      advance(1);
    end
    @(negedge clk);
  endtask

  task automatic set_id(input int r1, input bit u1, input int r2, input bit u2,
                        input int rd, input bit wr, input bit ld, input bit st);
    id_rs1 = RA'(r1); rs1_used = u1; id_rs2 = RA'(r2); rs2_used = u2;
    id_rd = RA'(rd); id_reg_wr = wr; id_mem_rd = ld; id_mem_wr = st;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_flush = 1'b0; instr_ready = 1'b1; data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample();
    chk("rst_enables", 32'({if_en, id_en, ex_en, ma_en, id_b, ex_b, flush}), 0);
    chk("rst_state", 32'({tmo, sc1}), 0);
    chk("rst_cnt0", 32'(sc0), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    do_reset();

    // Producer add x5, then a reader of x5 held in ID for three cycles
    set_id(0, 0, 0, 0, 5, 1, 0, 0); sample(); tick();
    set_id(5, 1, 0, 0, 0, 0, 0, 0); sample();
    chk("t1_fwd_ex", 32'(fwd1[0]), 32'h1);
    chk("t1_no_stall", 32'({if_en[0], id_en[0], ex_en[0], ma_en[0]}), 32'hF);
    chk("t3_stall_a", 32'(if_en[1]), 0);
    tick();
    sample();
    chk("t1_fwd_ma", 32'(fwd1[0]), 32'h2);
    chk("t3_stall_b", 32'(if_en[1]), 0);
    chk("t3_bubble", 32'(ex_b[1]), 1);
    tick();
    sample();
    chk("t3_resume", 32'(if_en[1]), 1);
    chk("t3_fwd", 32'(fwd1[1]), 0);
    chk("t3_cnt", 32'(sc1), 2);
    chk("t1_cnt", 32'(sc0), 0);
    tick();

    // Load-use: lw x7 followed by a reader of x7 on rs2
    do_reset();
    set_id(0, 0, 0, 0, 7, 1, 1, 0); sample(); tick();
    set_id(0, 0, 7, 1, 0, 0, 0, 0); sample();
    chk("t2_if_en", 32'(if_en[0]), 0);
    chk("t2_id_en", 32'(id_en[0]), 0);
    chk("t2_bubble", 32'(ex_b[0]), 1);
    chk("t2_ex_en", 32'(ex_en[0]), 1);
    tick();
    sample();
    chk("t2_fwd_ma", 32'(fwd2[0]), 32'h2);
    chk("t2_run", 32'(if_en[0]), 1);
    chk("t2_cnt", 32'(sc0), 1);
    tick();

    // Flush stretch: single pulse, then two back-to-back pulses
    do_reset();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      ex_flush = (i == 0);
      sample();
      if (flush[0] && ex_b[0]) n++;
      tick();
    end
    chk("t4_len3", n, 3);
    n = 0;
    for (int i = 0; i < 7; i++) begin
      ex_flush = (i < 2);
      sample();
      if (flush[0] && ex_b[0]) n++;
      tick();
    end
    chk("t4_len4", n, 4);
    ex_flush = 1'b0;

    // Store stuck in MA with data memory not ready for six cycles
    do_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 1); sample(); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); sample(); tick();
    data_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk($sformatf("t5_frozen%0d", i), 32'({if_en[0], id_en[0], ex_en[0], ma_en[0]}), 0);
      chk($sformatf("t5_tmo%0d", i), 32'(tmo[0]), 32'(i >= 4));
      tick();
    end
    data_ready = 1'b1;
    sample();
    chk("t5_resume", 32'({if_en[0], id_en[0], ex_en[0], ma_en[0]}), 32'hF);
    chk("t5_sticky", 32'(tmo[0]), 1);
    tick();
    sample();
    chk("t5_sticky2", 32'(tmo[0]), 1);
    tick();

    // x0 is never a hazard; then reset in the middle of a flush
    do_reset();
    set_id(0, 0, 0, 0, 0, 1, 1, 0); sample(); tick();
    set_id(0, 1, 0, 1, 0, 0, 0, 0); sample();
    chk("t6_fwd_x0", 32'({fwd1[0], fwd2[0]}), 0);
    chk("t6_no_stall", 32'({if_en[0], if_en[1]}), 32'h3);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_flush = 1'b1; sample(); tick();
    ex_flush = 1'b0; sample();
    chk("t6_in_flush", 32'(flush[0]), 1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("t6_rst_outs", 32'({if_en, id_en, ex_en, ma_en, id_b, ex_b, flush}), 0);
    chk("t6_rst_fwd", 32'({fwd1, fwd2}), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sample();
    chk("t6_run_flush", 32'(flush[0]), 0);
    chk("t6_run_en", 32'({if_en[0], id_en[0], ex_en[0], ma_en[0]}), 32'hF);
    tick();

    // Randomized traffic on a small register window to provoke hazards
    for (int i = 0; i < 600; i++) begin
      instr_ready = ($urandom_range(0, 4) != 0);
      data_ready  = ($urandom_range(0, 3) != 0);
      ex_flush    = ($urandom_range(0, 9) == 0);
      set_id(int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
             int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
             int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
      sample();
      tick();
    end
    chk("sat_cnt1", 32'(sc1), 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
